sram_controller: RTL and testbench

//  Sequences the off-chip 16-bit SRAM on behalf of the cache controller. It takes
//  one-word writes and two-word (64-bit) block reads on a 32-bit byte-address bus,
//  and turns each into a series of timed 16-bit SRAM accesses.
//  - Returns one ready pulse per completed request.
//  - Sits between the data cache (miss/write-through port) and the board SRAM pins.

---
 rtl/sram_controller.sv | 135 +++++++++++++
 tb/tb_sram_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Sequences 16-bit SRAM accesses for one-word writes and two-word block reads.
// Each request becomes a run of fixed-length access slots followed by a one-cycle ready pulse.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        read_en,
    input  logic        write_en,
    output logic [63:0] rdata,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_DQ_IN,
    output logic        SRAM_WE_N,
    output logic [1:0]  fsm_state
);

    localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [31:0]   off;
    logic [16:0]   word;
    logic [15:0]   whi;
    logic [1:0]    slot;
    logic [CW-1:0] cyc;
    logic          unused_bits;

    assign off         = address - BASE_ADDR;
    assign unused_bits = ^{off[31:19], off[1:0]};
    assign fsm_state   = state;

    // Slots 2/3 of a read go to the partner word (halfword bit 1 flipped).
    function automatic logic [17:0] slot_addr(input logic [16:0] w, input logic [1:0] s);
        return {w[16:1], w[0] ^ s[1], s[0]};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            word        <= '0;
            whi         <= '0;
            slot        <= '0;
            cyc         <= '0;
            rdata       <= '0;
            ready       <= 1'b0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_OUT <= '0;
            SRAM_DQ_OE  <= 1'b0;
            SRAM_WE_N   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    slot  <= '0;
                    cyc   <= '0;
                    if (write_en) begin
                        word        <= off[18:2];
                        whi         <= wdata[31:16];
                        SRAM_ADDR   <= {off[18:2], 1'b0};
                        SRAM_DQ_OUT <= wdata[15:0];
                        SRAM_DQ_OE  <= 1'b1;
                        SRAM_WE_N   <= 1'b0;
                        state       <= WRITE;
                    end else if (read_en) begin
                        word       <= off[18:2];
                        SRAM_ADDR  <= {off[18:2], 1'b0};
                        SRAM_DQ_OE <= 1'b0;
                        SRAM_WE_N  <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    if (cyc == LAST) begin
                        case (slot)
                            2'd0:    rdata[47:32] <= SRAM_DQ_IN;
                            2'd1:    rdata[63:48] <= SRAM_DQ_IN;
                            2'd2:    rdata[15:0]  <= SRAM_DQ_IN;
                            default: rdata[31:16] <= SRAM_DQ_IN;
                        endcase
                        cyc <= '0;
                        if (slot == 2'd3) begin
                            state <= DONE;
                            ready <= 1'b1;
                        end else begin
                            slot      <= slot + 2'd1;
                            SRAM_ADDR <= slot_addr(word, slot + 2'd1);
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                WRITE: begin
                    if (cyc == LAST) begin
                        cyc <= '0;
                        if (slot == 2'd1) begin
                            state      <= DONE;
                            ready      <= 1'b1;
                            SRAM_DQ_OE <= 1'b0;
                            SRAM_WE_N  <= 1'b1;
                        end else begin
                            slot        <= 2'd1;
                            SRAM_ADDR   <= slot_addr(word, 2'd1);
                            SRAM_DQ_OUT <= whi;
                            SRAM_WE_N   <= 1'b0;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                        // WE rises one cycle before the slot ends so address/data outlast it.
                        if ((cyc + 1'b1) == LAST) SRAM_WE_N <= 1'b1;
                    end
                end
                default: begin
                    ready <= 1'b0;
                    slot  <= '0;
                    cyc   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (WAIT_CYCLES 2 and 4), each on its own SRAM model.
// Expected block-read data is queued when a read is issued and compared when ready pulses.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic        sel = 1'b0;

    logic [63:0] rdata2, rdata4;
    logic        ready2, ready4;
    logic [17:0] addr2, addr4;
    logic [15:0] dq_out2, dq_out4, dq_in2, dq_in4;
    logic        oe2, oe4, we_n2, we_n4;
    logic [1:0]  st2, st4;

    logic [15:0] mem2 [0:262143];
    logic [15:0] mem4 [0:262143];

    logic [63:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          addr_log [0:64];
    int          we_log [0:64];
    int          we_lows, oe_highs;

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .read_en(req_rd & ~sel), .write_en(req_wr & ~sel),
        .rdata(rdata2), .ready(ready2), .SRAM_ADDR(addr2), .SRAM_DQ_OUT(dq_out2),
        .SRAM_DQ_OE(oe2), .SRAM_DQ_IN(dq_in2), .SRAM_WE_N(we_n2), .fsm_state(st2)
    );

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .read_en(req_rd & sel), .write_en(req_wr & sel),
        .rdata(rdata4), .ready(ready4), .SRAM_ADDR(addr4), .SRAM_DQ_OUT(dq_out4),
        .SRAM_DQ_OE(oe4), .SRAM_DQ_IN(dq_in4), .SRAM_WE_N(we_n4), .fsm_state(st4)
    );

    // SRAM models: asynchronous read, write committed on the rising WE edge.
    assign dq_in2 = mem2[addr2];
    assign dq_in4 = mem4[addr4];
    always @(posedge we_n2) if (oe2 === 1'b1) mem2[addr2] <= dq_out2;
    always @(posedge we_n4) if (oe4 === 1'b1) mem4[addr4] <= dq_out4;

    logic [63:0] rdata_s;
    logic        ready_s, oe_s, we_n_s;
    logic [17:0] addr_s;
    assign rdata_s = sel ? rdata4 : rdata2;
    assign ready_s = sel ? ready4 : ready2;
    assign oe_s    = sel ? oe4 : oe2;
    assign we_n_s  = sel ? we_n4 : we_n2;
    assign addr_s  = sel ? addr4 : addr2;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, input int exp_lat, input logic hold,
                          input string tag);
        int  n;
        bit  seen;
        @(negedge clk);
        address = a;
        wdata   = d;
        req_wr  = wr;
        req_rd  = rd;
        @(posedge clk);
        n = 0;
        seen = 0;
        we_lows = 0;
        oe_highs = 0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            addr_log[n] = int'(addr_s);
            we_log[n]   = int'(we_n_s);
            if (!we_n_s) we_lows++;
            if (oe_s) oe_highs++;
            if (ready_s) seen = 1;
            if (!hold || ready_s) begin
                req_wr = 1'b0;
                req_rd = 1'b0;
            end
        end
        check_val({tag, "_lat"}, 64'(n), 64'(exp_lat));
        if (seen && rd && !wr) begin
            check_val({tag, "_q"}, 64'(exp_q.size()), 64'd1);
            if (exp_q.size() > 0) check_val({tag, "_rdata"}, rdata_s, exp_q.pop_front());
        end
        @(negedge clk);
        check_val({tag, "_pulse"}, 64'(ready_s), 64'd0);
    endtask

    initial begin
        int cnt;
        int seq3 [0:3];
        for (int i = 0; i < 262144; i++) begin
            mem2[i] = 16'h0000;
            mem4[i] = 16'h0000;
        end
        mem2[2] = 16'h5678;
        mem2[3] = 16'h1234;
        mem4[0] = 16'hBEEF;
        mem4[1] = 16'hDEAD;
        mem4[2] = 16'h5678;
        mem4[3] = 16'h1234;

        // reset held with a read request pending
        req_rd = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (!we_n2 || oe2) cnt++;
        end
        check_val("rst_access", 64'(cnt), 64'd0);
        check_val("rst_ready", 64'(ready2), 64'd0);
        check_val("rst_we_n", 64'(we_n2), 64'd1);
        check_val("rst_oe", 64'(oe2), 64'd0);
        check_val("rst_addr", 64'(addr2), 64'd0);
        check_val("rst_rdata", rdata2, 64'd0);
        check_val("rst_state", 64'(st2), 64'd0);
        req_rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // word write
        run_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 5, 1'b0, "wr");
        check_val("wr_mem0", 64'(mem2[0]), 64'hBEEF);
        check_val("wr_mem1", 64'(mem2[1]), 64'hDEAD);
        check_val("wr_we_lows", 64'(we_lows), 64'd2);
        check_val("wr_oe_highs", 64'(oe_highs), 64'd4);
        check_val("wr_we_c1", 64'(we_log[1]), 64'd0);
        check_val("wr_we_c2", 64'(we_log[2]), 64'd1);
        check_val("wr_addr_c2", 64'(addr_log[2]), 64'd0);
        check_val("wr_addr_c3", 64'(addr_log[3]), 64'd1);
        check_val("wr_rdata_hold", rdata2, 64'd0);

        // block read from the odd word: partner word fills the low half
        exp_q.push_back(64'h12345678_DEADBEEF);
        run_op(1'b0, 1'b1, 32'd1028, 32'd0, 9, 1'b0, "rd");
        seq3[0] = 2; seq3[1] = 3; seq3[2] = 0; seq3[3] = 1;
        for (int i = 1; i <= 8; i++)
            check_val($sformatf("rd_addr_c%0d", i), 64'(addr_log[i]), 64'(seq3[(i - 1) / 2]));
        check_val("rd_we_lows", 64'(we_lows), 64'd0);
        check_val("rd_oe_highs", 64'(oe_highs), 64'd0);

        // simultaneous read and write: write wins, nothing follows
        run_op(1'b1, 1'b1, 32'd1032, 32'h0000CAFE, 5, 1'b1, "both");
        check_val("both_mem4", 64'(mem2[4]), 64'hCAFE);
        check_val("both_mem5", 64'(mem2[5]), 64'h0000);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready2 || st2 != 2'd0) cnt++;
        end
        check_val("both_no_follow", 64'(cnt), 64'd0);
        check_val("both_rdata_hold", rdata2, 64'h12345678_DEADBEEF);

        // reset in cycle 3 of a read
        @(negedge clk);
        address = 32'd1024;
        req_rd  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("abort_rdata", rdata2, 64'd0);
        check_val("abort_addr", 64'(addr2), 64'd0);
        check_val("abort_state", 64'(st2), 64'd0);
        check_val("abort_we_oe", 64'({we_n2, oe2}), 64'b10);
        cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (ready2) cnt++;
        end
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ready2) cnt++;
        end
        check_val("abort_no_ready", 64'(cnt), 64'd0);
        exp_q.push_back(64'hDEADBEEF_12345678);
        run_op(1'b0, 1'b1, 32'd1024, 32'd0, 9, 1'b0, "rd_after");

        // longer access slots
        sel = 1'b1;
        exp_q.push_back(64'hDEADBEEF_12345678);
        run_op(1'b0, 1'b1, 32'd1024, 32'd0, 17, 1'b0, "rd_w4");
        for (int i = 1; i <= 16; i++)
            check_val($sformatf("w4_addr_c%0d", i), 64'(addr_log[i]), 64'((i - 1) / 4));

        check_val("q_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
